// File: rtl/gauss_window_feeder.sv
// Line-buffered 3x3 window feeder for the Gaussian smoothing stage.
// Buffers three image rows and replays each full neighbourhood as a 9-cycle burst.
module gauss_window_feeder #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pix_out,
    output logic       pix_en,
    output logic       busy,
    output logic       frame_done,
    output logic       overflow
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int DEPTH = 3 * IMG_W;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, WRITE, EMIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    slot_q, slot_d;
    logic [CW-1:0] org_col_q, org_col_d;
    logic [1:0]    org_slot_q, org_slot_d;
    logic          last_q, last_d;
    logic          pend_q, pend_d;
    logic [7:0]    pbyte_q, pbyte_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    pix_out_q, pix_out_d;
    logic          pix_en_q, pix_en_d;
    logic          fd_q, fd_d;

    logic [7:0]    mem [DEPTH];
    logic          win;
    logic [1:0]    roff, coff, rslot;
    logic [2:0]    ssum;
    logic [CW-1:0] rcol;
    logic [AW-1:0] wr_addr, rd_addr;

    assign win = (row_q >= RW'(2)) && (col_q >= CW'(2));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: WRITE follows a strobe directly so the write lands in N+1
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_q || rx_valid) state_d = WRITE;
            WRITE:   state_d = win ? EMIT : IDLE;
            EMIT:    if (cnt_q == 4'd9) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Position counters, window origin latch and pending-byte capture
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        slot_d     = slot_q;
        org_col_d  = org_col_q;
        org_slot_d = org_slot_q;
        last_d     = last_q;
        pend_d     = pend_q;
        pbyte_d    = pbyte_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        if (state_q == WRITE) begin
            pend_d = 1'b0;
            cnt_d  = 4'd0;
            if (win) begin
                org_col_d  = col_q;
                org_slot_d = slot_q;
                last_d     = (row_q == ROW_MAX) && (col_q == COL_MAX);
            end
            if (col_q == COL_MAX) begin
                col_d = '0;
                if (row_q == ROW_MAX) begin
                    row_d  = '0;
                    slot_d = 2'd0;
                end else begin
                    row_d  = row_q + 1'b1;
                    slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (state_q == EMIT) cnt_d = cnt_q + 4'd1;
        if (rx_valid) begin
            if (pend_q && state_q != WRITE) begin
                ovf_d = 1'b1;
            end else begin
                pend_d  = 1'b1;
                pbyte_d = rx_data;
            end
        end
    end

    // Window read address: slot of row R-2 is origin slot + 1 (mod 3)
    always_comb begin
        case (cnt_q)
            4'd0:    begin roff = 2'd0; coff = 2'd0; end
            4'd1:    begin roff = 2'd0; coff = 2'd1; end
            4'd2:    begin roff = 2'd0; coff = 2'd2; end
            4'd3:    begin roff = 2'd1; coff = 2'd0; end
            4'd4:    begin roff = 2'd1; coff = 2'd1; end
            4'd5:    begin roff = 2'd1; coff = 2'd2; end
            4'd6:    begin roff = 2'd2; coff = 2'd0; end
            4'd7:    begin roff = 2'd2; coff = 2'd1; end
            4'd8:    begin roff = 2'd2; coff = 2'd2; end
            default: begin roff = 2'd0; coff = 2'd0; end
        endcase
        ssum    = {1'b0, org_slot_q} + {1'b0, roff} + 3'd1;
        rslot   = (ssum >= 3'd3) ? 2'(ssum - 3'd3) : ssum[1:0];
        rcol    = org_col_q - CW'(2) + CW'(coff);
        rd_addr = AW'(int'(rslot) * IMG_W + int'(rcol));
        wr_addr = AW'(int'(slot_q) * IMG_W + int'(col_q));
    end

    // Line buffer write port, contents survive reset
    always_ff @(posedge clk) begin
        if (state_q == WRITE) mem[wr_addr] <= pbyte_q;
    end

    // FSM outputs: busy plus next values of the registered burst outputs
    always_comb begin
        busy      = (state_q != IDLE);
        pix_en_d  = (state_q == EMIT) && (cnt_q < 4'd9);
        pix_out_d = pix_en_d ? mem[rd_addr] : 8'd0;
        fd_d      = (state_q == EMIT) && (cnt_q == 4'd9) && last_q;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            slot_q     <= 2'd0;
            org_col_q  <= '0;
            org_slot_q <= 2'd0;
            last_q     <= 1'b0;
            pend_q     <= 1'b0;
            pbyte_q    <= 8'd0;
            ovf_q      <= 1'b0;
            cnt_q      <= 4'd0;
            pix_out_q  <= 8'd0;
            pix_en_q   <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            slot_q     <= slot_d;
            org_col_q  <= org_col_d;
            org_slot_q <= org_slot_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            pbyte_q    <= pbyte_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            pix_out_q  <= pix_out_d;
            pix_en_q   <= pix_en_d;
            fd_q       <= fd_d;
        end
    end

    assign pix_out    = pix_out_q;
    assign pix_en     = pix_en_q;
    assign frame_done = fd_q;
    assign overflow   = ovf_q;
endmodule
